aes_key_loader: RTL and testbench

AES_KEY_LOADER -- requirements
Module: aes_key_loader

---
 rtl/aes_key_loader.sv | 168 ++++++++++++++++
 tb/tb_aes_key_loader.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_loader.sv
// Streams a 128-bit cipher key into key_expand, waits for its done, then serves round-key reads.
// Optional macro LAST_RK_CACHE_EN keeps the last fetched round key so that a repeat request is answered directly.
module aes_key_loader #(
    parameter int unsigned DONE_TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [127:0] key_in,
    input  logic         key_valid,
    output logic         key_ready,
    output logic         ke_start,
    output logic [31:0]  ke_cipher_key,
    input  logic         ke_done,
    output logic [3:0]   ke_round_key_num,
    output logic [1:0]   ke_r_index,
    input  logic [31:0]  ke_round_key,
    output logic         keys_ready,
    input  logic         rk_req,
    input  logic [3:0]   rk_num,
    output logic         rk_ack,
    output logic [127:0] rk_data,
    output logic         err
);
    localparam int unsigned TW         = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;
    localparam logic [3:0]  LAST_ROUND = 4'd10;

    typedef enum logic [2:0] {IDLE, START, LOAD, WAIT_DONE, READY, FETCH, RESP} state_e;

    state_e         state_q;
    logic [127:0]   key_q;
    logic [1:0]     word_q;
    logic [TW-1:0]  timer_q;
    logic [95:0]    rk_buf_q;
    logic           ke_start_q;
    logic [31:0]    ke_key_q;
    logic [3:0]     ke_num_q;
    logic [1:0]     ke_idx_q;
    logic           keys_ready_q;
    logic           rk_ack_q;
    logic [127:0]   rk_data_q;
    logic           err_q;
`ifdef LAST_RK_CACHE_EN
    logic           cache_vld_q;
    logic [3:0]     cache_num_q;
    logic [127:0]   cache_data_q;
`endif

    // A pending round-key request in READY blocks key acceptance, giving it priority.
    assign key_ready = (state_q == IDLE) || ((state_q == READY) && !rk_req);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            key_q        <= '0;
            word_q       <= '0;
            timer_q      <= '0;
            rk_buf_q     <= '0;
            ke_start_q   <= 1'b0;
            ke_key_q     <= '0;
            ke_num_q     <= '0;
            ke_idx_q     <= '0;
            keys_ready_q <= 1'b0;
            rk_ack_q     <= 1'b0;
            rk_data_q    <= '0;
            err_q        <= 1'b0;
`ifdef LAST_RK_CACHE_EN
            cache_vld_q  <= 1'b0;
            cache_num_q  <= '0;
            cache_data_q <= '0;
`endif
        end else begin
            ke_start_q <= 1'b0;
            rk_ack_q   <= 1'b0;
            if (key_valid && key_ready) begin
                state_q      <= START;
                key_q        <= key_in;
                keys_ready_q <= 1'b0;
                ke_start_q   <= 1'b1;
`ifdef LAST_RK_CACHE_EN
                cache_vld_q  <= 1'b0;
`endif
            end else begin
                case (state_q)
                    START: begin
                        state_q  <= LOAD;
                        ke_key_q <= key_q[127:96];
                        key_q    <= {key_q[95:0], 32'h0};
                        word_q   <= '0;
                    end
                    LOAD: begin
                        if (word_q == 2'd3) begin
                            state_q  <= WAIT_DONE;
                            ke_key_q <= '0;
                            timer_q  <= '0;
                        end else begin
                            ke_key_q <= key_q[127:96];
                            key_q    <= {key_q[95:0], 32'h0};
                            word_q   <= word_q + 2'd1;
                        end
                    end
                    WAIT_DONE: begin
                        if (ke_done) begin
                            state_q      <= READY;
                            keys_ready_q <= 1'b1;
                            timer_q      <= '0;
                        end else if (timer_q == TW'(DONE_TIMEOUT - 1)) begin
                            state_q <= IDLE;
                            err_q   <= 1'b1;
                            timer_q <= '0;
                        end else begin
                            timer_q <= timer_q + TW'(1);
                        end
                    end
                    READY: begin
                        if (rk_req) begin
                            if (rk_num > LAST_ROUND) begin
                                state_q   <= RESP;
                                rk_ack_q  <= 1'b1;
                                rk_data_q <= '0;
`ifdef LAST_RK_CACHE_EN
                            end else if (cache_vld_q && (cache_num_q == rk_num)) begin
                                state_q   <= RESP;
                                rk_ack_q  <= 1'b1;
                                rk_data_q <= cache_data_q;
`endif
                            end else begin
                                state_q  <= FETCH;
                                ke_num_q <= rk_num;
                                ke_idx_q <= '0;
                            end
                        end
                    end
                    FETCH: begin
                        // Words gather in rk_buf_q so rk_data only changes together with rk_ack.
                        if (ke_idx_q == 2'd3) begin
                            state_q   <= RESP;
                            rk_ack_q  <= 1'b1;
                            rk_data_q <= {rk_buf_q, ke_round_key};
                            ke_num_q  <= '0;
                            ke_idx_q  <= '0;
`ifdef LAST_RK_CACHE_EN
                            cache_vld_q  <= 1'b1;
                            cache_num_q  <= ke_num_q;
                            cache_data_q <= {rk_buf_q, ke_round_key};
`endif
                        end else begin
                            rk_buf_q <= {rk_buf_q[63:0], ke_round_key};
                            ke_idx_q <= ke_idx_q + 2'd1;
                        end
                    end
                    RESP:    state_q <= READY;
                    IDLE:    state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign ke_start         = ke_start_q;
    assign ke_cipher_key    = ke_key_q;
    assign ke_round_key_num = ke_num_q;
    assign ke_r_index       = ke_idx_q;
    assign keys_ready       = keys_ready_q;
    assign rk_ack           = rk_ack_q;
    assign rk_data          = rk_data_q;
    assign err              = err_q;

endmodule

// File: tb/tb_aes_key_loader.sv
// Bench for aes_key_loader: acts as key_expand (real AES-128 schedule) and checks every output each cycle
// against a scenario-level model; honours LAST_RK_CACHE_EN when defined.
module tb_aes_key_loader;
    localparam int unsigned DT = 20;

    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] key_in;
    logic         key_valid;
    logic         key_ready;
    logic         ke_start;
    logic [31:0]  ke_cipher_key;
    logic         ke_done;
    logic [3:0]   ke_round_key_num;
    logic [1:0]   ke_r_index;
    logic [31:0]  ke_round_key;
    logic         keys_ready;
    logic         rk_req;
    logic [3:0]   rk_num;
    logic         rk_ack;
    logic [127:0] rk_data;
    logic         err;

    always #5 clk = ~clk;

    aes_key_loader #(.DONE_TIMEOUT(DT)) dut (
        .clk(clk), .reset(reset), .key_in(key_in), .key_valid(key_valid), .key_ready(key_ready),
        .ke_start(ke_start), .ke_cipher_key(ke_cipher_key), .ke_done(ke_done),
        .ke_round_key_num(ke_round_key_num), .ke_r_index(ke_r_index), .ke_round_key(ke_round_key),
        .keys_ready(keys_ready), .rk_req(rk_req), .rk_num(rk_num), .rk_ack(rk_ack),
        .rk_data(rk_data), .err(err)
    );

    // ---------------- key_expand stand-in: full AES-128 schedule ----------------
    logic [7:0]  sb [256];
    logic [31:0] rk_words [44];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] a);
        logic [7:0] inv;
        inv = 8'h01;
        if (a == 8'h00) inv = 8'h00;
        else for (int i = 0; i < 254; i++) inv = gmul(inv, a);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    task automatic expand(input logic [127:0] k);
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) rk_words[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = rk_words[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            rk_words[i] = rk_words[i-4] ^ t;
        end
    endtask

    always_comb begin
        ke_round_key = 32'h0;
        if (ke_round_key_num <= 4'd10)
            ke_round_key = rk_words[int'(ke_round_key_num) * 4 + int'(ke_r_index)];
    end

    function automatic logic [127:0] round_key(input int n);
        return {rk_words[4*n], rk_words[4*n+1], rk_words[4*n+2], rk_words[4*n+3]};
    endfunction

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    typedef enum {M_IDLE, M_READY, M_BUSY} mode_e;
    mode_e        mode;
    bit           m_keys_ready, m_err, chk_en;
    logic         e_ke_start, e_rk_ack;
    logic [31:0]  e_ck;
    logic [3:0]   e_num;
    logic [1:0]   e_idx;
    bit           e_data_chk;
    logic [127:0] e_data;
    bit           c_vld;
    logic [3:0]   c_num;
    logic [127:0] c_data;
    logic [31:0]  fips_w [4];

    always @(negedge clk) begin
        if (chk_en) begin
            chk("key_ready", 128'(key_ready), 128'((mode == M_IDLE) || (mode == M_READY && !rk_req)));
            chk("ke_start", 128'(ke_start), 128'(e_ke_start));
            chk("ke_cipher_key", 128'(ke_cipher_key), 128'(e_ck));
            chk("ke_round_key_num", 128'(ke_round_key_num), 128'(e_num));
            chk("ke_r_index", 128'(ke_r_index), 128'(e_idx));
            chk("keys_ready", 128'(keys_ready), 128'(m_keys_ready));
            chk("rk_ack", 128'(rk_ack), 128'(e_rk_ack));
            chk("err", 128'(err), 128'(m_err));
            if (e_data_chk) chk("rk_data", rk_data, e_data);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        e_ke_start = 1'b0; e_ck = '0; e_num = '0; e_idx = '0; e_rk_ack = 1'b0; e_data_chk = 1'b0;
    endtask

    task automatic model_reset();
        mode = M_IDLE; m_keys_ready = 1'b0; m_err = 1'b0; c_vld = 1'b0;
        e_data_chk = 1'b1; e_data = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_reset();
    endtask

    // delay < 0 means ke_done never arrives.
    task automatic load_key(input logic [127:0] k, input int delay, input bit stale, input bit pin);
        key_valid = 1'b1; key_in = k;
        step();
        key_valid = 1'b0; key_in = {$urandom, $urandom, $urandom, $urandom};
        mode = M_BUSY; m_keys_ready = 1'b0; c_vld = 1'b0; expand(k);
        e_ke_start = 1'b1; ke_done = stale;
        for (int i = 0; i < 4; i++) begin
            step();
            e_ck = k[127-32*i -: 32]; ke_done = stale;
            if (pin) begin
                @(negedge clk);
                chk("fips_key_word", 128'(ke_cipher_key), 128'(fips_w[i]));
            end
        end
        step();
        for (int w = 0; w < int'(DT); w++) begin
            ke_done = (w == delay);
            step();
            if (ke_done) begin
                ke_done = 1'b0; mode = M_READY; m_keys_ready = 1'b1;
                return;
            end
        end
        ke_done = 1'b0; mode = M_IDLE; m_err = 1'b1;
    endtask

    task automatic fetch(input logic [3:0] num, input bit both, input bit lit_en, input logic [127:0] lit);
        bit hit;
        hit = 1'b0;
`ifdef LAST_RK_CACHE_EN
        hit = c_vld && (c_num == num);
`endif
        rk_req = 1'b1; rk_num = num;
        if (both) begin key_valid = 1'b1; key_in = {$urandom, $urandom, $urandom, $urandom}; end
        step();
        key_valid = 1'b0; mode = M_BUSY;
        if (num > 4'd10 || (hit && num <= 4'd10)) begin
            e_data = (num > 4'd10) ? 128'h0 : c_data;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (i > 0) step();
                e_num = num; e_idx = 2'(i);
            end
            step();
            e_data = round_key(int'(num));
            c_vld = 1'b1; c_num = num; c_data = e_data;
        end
        e_rk_ack = 1'b1; e_data_chk = 1'b1;
        if (lit_en) begin
            @(negedge clk);
            chk("rk_data_literal", rk_data, lit);
        end
        step();
        rk_req = 1'b0; rk_num = 4'($urandom_range(0, 15)); mode = M_READY;
    endtask

    task automatic fetch_then_reset(input logic [3:0] num);
        rk_req = 1'b1; rk_num = num;
        step();
        mode = M_BUSY;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) step();
            e_num = num; e_idx = 2'(i);
        end
        reset = 1'b1;
        step();
        reset = 1'b0; rk_req = 1'b0;
        model_reset();
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0] last;
        logic [3:0] n;
        for (int i = 0; i < 256; i++) sb[i] = sbox_calc(8'(i));
        fips_w[0] = 32'h2b7e1516; fips_w[1] = 32'h28aed2a6;
        fips_w[2] = 32'habf71588; fips_w[3] = 32'h09cf4f3c;
        for (int i = 0; i < 44; i++) rk_words[i] = '0;
        chk_en = 1'b0; reset = 1'b1; key_valid = 1'b0; key_in = '0;
        ke_done = 1'b0; rk_req = 1'b0; rk_num = '0; mode = M_IDLE;
        e_ke_start = 1'b0; e_ck = '0; e_num = '0; e_idx = '0; e_rk_ack = 1'b0;
        c_vld = 1'b0; c_num = '0; c_data = '0;
        step();
        step();
        reset = 1'b0;
        model_reset();
        chk_en = 1'b1;
        step();

        // Known-answer key load and fetches, stale done during load.
        load_key(128'h2b7e151628aed2a6abf7158809cf4f3c, 3, 1'b1, 1'b1);
        fetch(4'd1, 1'b0, 1'b1, 128'ha0fafe1788542cb123a339392a6c7605);
        fetch(4'd10, 1'b0, 1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        fetch(4'd10, 1'b1, 1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        fetch(4'd12, 1'b0, 1'b1, 128'h0);
        fetch(4'd10, 1'b0, 1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        fetch(4'd0, 1'b0, 1'b1, 128'h2b7e151628aed2a6abf7158809cf4f3c);

        // Timeout, then a reload whose done lands on the last allowed cycle.
        load_key({$urandom, $urandom, $urandom, $urandom}, -1, 1'b0, 1'b0);
        step();
        load_key({$urandom, $urandom, $urandom, $urandom}, int'(DT) - 1, 1'b1, 1'b0);
        fetch(4'd15, 1'b0, 1'b0, '0);
        fetch(4'd5, 1'b0, 1'b0, '0);
        fetch_then_reset(4'd7);

        last = 4'd0;
        for (int it = 0; it < 25; it++) begin
            load_key({$urandom, $urandom, $urandom, $urandom}, int'($urandom_range(0, DT - 1)),
                     1'($urandom_range(0, 1)), 1'b0);
            for (int f = 0; f < int'($urandom_range(1, 5)); f++) begin
                n = ($urandom_range(0, 3) == 0) ? last : 4'($urandom_range(0, 15));
                last = n;
                fetch(n, 1'($urandom_range(0, 3) == 0), 1'b0, '0);
                for (int g = 0; g < int'($urandom_range(0, 2)); g++) step();
            end
            if (it % 8 == 7) do_reset();
        end
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
